// File: rtl/scm_tcdm_port.sv
// TCDM responder front-end for a 1R/1W latch SCM register file.
// Optional post-reset array clear: define SCM_TCDM_PORT_INIT_EN.
module scm_tcdm_port #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_BYTE-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  init_done_o,
  output logic                  rf_re_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  output logic                  rf_we_o,
  output logic [ADDR_WIDTH-1:0] rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic [NUM_BYTE-1:0]   rf_be_o
);

  logic                  in_init;
  logic [ADDR_WIDTH-1:0] init_addr;

`ifdef SCM_TCDM_PORT_INIT_EN
  typedef enum logic {INIT, READY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] icnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      icnt_q  <= '0;
    end else if (state_q == INIT) begin
      icnt_q <= icnt_q + 1'b1;
      if (icnt_q == '1) state_q <= READY;
    end
  end

  assign in_init     = (state_q == INIT);
  assign init_addr   = icnt_q;
  assign init_done_o = (state_q == READY);
`else
  assign in_init     = 1'b0;
  assign init_addr   = '0;
  assign init_done_o = 1'b1;
`endif

  logic [1:0]            cnt_q, cnt_d;
  logic                  wptr_q, wptr_d;
  logic                  rptr_q, rptr_d;
  logic                  infl_q, infl_d;
  logic                  infl_we_q, infl_we_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  fifo_empty;
  logic                  push, pop_fifo, bypass;
  logic                  gnt;

  assign fifo_empty = (cnt_q == 2'd0);
  assign gnt = ~in_init & req_i & ((cnt_q + {1'b0, infl_q}) < 2'd2);
  assign resp_data = infl_we_q ? '0 : rf_rdata_i;

  // Fall-through: an arriving response skips the FIFO when it is empty.
  assign rvalid_o = ~fifo_empty | infl_q;
  assign rdata_o  = ~fifo_empty ? fifo_q[rptr_q] :
                    (infl_q ? resp_data : '0);

  assign bypass   = infl_q & fifo_empty & rready_i;
  assign push     = infl_q & ~bypass;
  assign pop_fifo = ~fifo_empty & rready_i;

  always_comb begin
    cnt_d     = cnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    fifo_d    = fifo_q;
    infl_d    = gnt;
    infl_we_d = gnt & we_i;
    if (push) begin
      fifo_d[wptr_q] = resp_data;
      wptr_d         = ~wptr_q;
    end
    if (pop_fifo) rptr_d = ~rptr_q;
    case ({push, pop_fifo})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      infl_q    <= 1'b0;
      infl_we_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      infl_q    <= infl_d;
      infl_we_q <= infl_we_d;
      fifo_q    <= fifo_d;
    end
  end

  assign gnt_o      = gnt;
  assign rf_re_o    = gnt & ~we_i;
  assign rf_raddr_o = addr_i;
  assign rf_we_o    = in_init | (gnt & we_i);
  assign rf_waddr_o = in_init ? init_addr : addr_i;
  assign rf_wdata_o = in_init ? '0 : wdata_i;
  assign rf_be_o    = in_init ? '1 : be_i;

endmodule
